// File: rtl/rle_pkg.sv
// Shared types and defaults for the RLE encoder/decoder pair of the EEG path.
package rle_pkg;
    localparam int RLE_DATA_W = 8;
    localparam int RLE_LEN_W  = 8;
    localparam int RLE_MARKER = 0;

    typedef enum logic [1:0] {LIT, LEN, RUN} rle_state_t;
endpackage

// File: rtl/rle_out_reg.sv
// Single-entry valid/ready output register carrying a coefficient and its frame-last flag.
module rle_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_last,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last
);
    // Callers only assert load when the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: literals pass through, MARKER + length expands to a zero run.
// Optional sticky protocol-error flag enabled by defining RLE_DEC_ERR_EN.
module rle_decoder
    import rle_pkg::*;
#(
    parameter int DATA_W = RLE_DATA_W,
    parameter int LEN_W  = RLE_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready
`ifdef RLE_DEC_ERR_EN
    ,
    output logic              err
`endif
);
    rle_state_t        state;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  len;
    logic              run_last;
    logic              in_fire, is_marker, run_step, lit_load, len_load;
    logic              load, load_last;
    logic [DATA_W-1:0] load_data;

    assign len       = in_data[LEN_W-1:0];
    assign is_marker = (in_data == DATA_W'(RLE_MARKER));
    assign in_ready  = (state != RUN) && (!out_valid || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign lit_load  = in_fire && (state == LIT) && !is_marker;
    assign len_load  = in_fire && (state == LEN) && (len != '0);
    assign run_step  = (state == RUN) && (!out_valid || out_ready);
    assign load      = lit_load || len_load || run_step;

    always_comb begin
        load_data = '0;
        load_last = 1'b0;
        if (lit_load) begin
            load_data = in_data;
            load_last = in_last;
        end else if (len_load) begin
            load_last = in_last && (len == LEN_W'(1));
        end else if (run_step) begin
            load_last = run_last && (cnt == LEN_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= LIT;
            cnt      <= '0;
            run_last <= 1'b0;
        end else begin
            case (state)
                LIT: if (in_fire && is_marker) state <= LEN;
                LEN: if (in_fire) begin
                    // A zero length emits nothing and simply resynchronises on LIT.
                    run_last <= in_last;
                    cnt      <= (len == '0) ? '0 : len - LEN_W'(1);
                    state    <= (len > LEN_W'(1)) ? RUN : LIT;
                end
                RUN: if (run_step) begin
                    cnt <= cnt - LEN_W'(1);
                    if (cnt == LEN_W'(1)) state <= LIT;
                end
                default: state <= LIT;
            endcase
        end
    end

`ifdef RLE_DEC_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else if (in_fire && (((state == LIT) && is_marker && in_last) ||
                             ((state == LEN) && (len == '0))))
            err <= 1'b1;
    end
`endif

    rle_out_reg #(.W(DATA_W)) u_out (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );
endmodule

// File: tb/tb_rle_decoder.sv
// Scoreboard bench for rle_decoder: directed tokens push expected coefficients, a monitor pops them.
module tb_rle_decoder;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid, in_last, in_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last, out_ready;
`ifdef RLE_DEC_ERR_EN
    logic       err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    rle_decoder #(.DATA_W(8), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef RLE_DEC_ERR_EN
        , .err(err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_run(input int n, input logic last);
        for (int i = 0; i < n; i++) sb.push_back({last && (i == n - 1), 8'h00});
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int k = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) chk("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || out_valid) && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops on every output handshake and checks stability across stalls.
    logic [8:0] held;
    logic       held_vld = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_vld <= 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_value", {out_last, out_data}, held);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", {out_last, out_data}, 9'h1ff);
                else chk("out_value", {out_last, out_data}, sb.pop_front());
            end
            held_vld <= out_valid && !out_ready;
            held     <= {out_last, out_data};
        end
    end

    logic [4:0] pat;
    int         k;

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 1);
`ifdef RLE_DEC_ERR_EN
        chk("rst_err", err, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back literals, 1-cycle latency each
        sb.push_back({1'b0, 8'd5});  send(8'd5, 1'b0);
        chk("lat_5", {out_valid, out_data}, {1'b1, 8'd5});
        sb.push_back({1'b0, 8'hfd}); send(8'hfd, 1'b0);
        chk("lat_m3", {out_valid, out_data}, {1'b1, 8'hfd});
        sb.push_back({1'b0, 8'd7});  send(8'd7, 1'b0);
        chk("lat_7", {out_valid, out_data}, {1'b1, 8'd7});
        drain();

        // 9, run of 4, -2
        sb.push_back({1'b0, 8'd9}); send(8'd9, 1'b0);
        send(8'd0, 1'b0);
        push_run(4, 1'b0);          send(8'd4, 1'b0);
        k = 0;
        while (!in_ready && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("run4_ready_low", k, 3);
        sb.push_back({1'b0, 8'hfe}); send(8'hfe, 1'b0);
        drain();

        // Run of 1 closing a frame
        send(8'd0, 1'b0);
        push_run(1, 1'b1); send(8'd1, 1'b1);
        chk("run1_last", {out_valid, out_last}, 2'b11);
        chk("run1_back_lit", in_ready, 1);
        drain();

        // Run of 3 under toggled backpressure
        send(8'd0, 1'b0);
        push_run(3, 1'b0); send(8'd3, 1'b0);
        pat = 5'b11001;  // applied LSB first: 1,0,0,1,1
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        drain();

        // Zero-length run
        send(8'd0, 1'b0);
        send(8'd0, 1'b0);
        chk("n0_no_out", out_valid, 0);
        chk("n0_in_ready", in_ready, 1);
`ifdef RLE_DEC_ERR_EN
        chk("n0_err_set", err, 1);
`endif
        for (int i = 1; i <= 10; i++) begin
            sb.push_back({1'b0, 8'(i)});
            send(8'(i), 1'b0);
        end
        drain();
`ifdef RLE_DEC_ERR_EN
        chk("err_sticky", err, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("err_cleared", err, 0);
`endif

        // in_last on a MARKER: error with the macro, ignored otherwise
        send(8'd0, 1'b1);
`ifdef RLE_DEC_ERR_EN
        chk("marker_last_err", err, 1);
`endif
        push_run(2, 1'b0); send(8'd2, 1'b0);
        drain();

        // Reset in the middle of a long run
        send(8'd0, 1'b0);
        push_run(100, 1'b0); send(8'd100, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        chk("run100_busy", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        chk("midrun_rst_valid", out_valid, 0);
        chk("midrun_rst_ready", in_ready, 1);
        sb.push_back({1'b0, 8'd6}); send(8'd6, 1'b0);
        chk("post_rst_lit", {out_valid, out_data}, {1'b1, 8'd6});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/rle_decoder.md
# rle_decoder

Run-length decoder on the decompression side of the DWT+RLE EEG path. It consumes the token stream produced after hard thresholding and run-length encoding. Literal nonzero coefficients pass through unchanged. Each zero-run token pair expands back into the original sequence of zero coefficients. Output feeds the inverse-DWT stage one coefficient per cycle under valid/ready flow control.

## Interface
- DATA_W, 8, coefficient and token width (signed two's complement)
- LEN_W, 8, run-length field width; must be ≤ DATA_W
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset: synchronous, active-low; one clock, `clk`
- in_data  input  DATA_W  token: literal coefficient, zero marker, or run length
- in_valid  input  1  token present
- in_last  input  1  token closes a frame
- in_ready  output  1  decoder accepts token this cycle
- out_data  output  DATA_W  reconstructed coefficient
- out_valid  output  1  coefficient present
- out_last  output  1  final coefficient of frame
- out_ready  input  1  downstream accepts
- err  output  1  sticky protocol error (only with RLE_DEC_ERR_EN)

## Operation
- Token format: in_data == 0 is MARKER. The next token's low LEN_W bits give N, the number of zeros, in the range 1..2^LEN_W−1. Any other value is a literal.
- FSM states: LIT (reset), LEN, RUN.
  - LIT, accepted MARKER: go to LEN. No output.
  - LIT, accepted literal: load the output register with the literal. out_last = in_last.
  - LEN, accepted length N ≥ 1: load a zero into the output register. cnt = N−1. If cnt == 0, return to LIT; otherwise go to RUN.
  - RUN, each output handshake: load a zero, cnt−1. When the zero with cnt reaching 0 is loaded, return to LIT.
- out_last on a run is set only on the final zero, and only if the length token carried in_last.
- Fire conditions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != RUN) & (!out_valid | out_ready). No token is accepted while a run is expanding.
- Output register behaviour:
  - Loads on in_fire (literal or length) or on a RUN step.
  - Holds while out_valid & !out_ready.
  - Clears out_valid on out_fire with no new load.
- Length N = 0 is a protocol error. It produces no output and returns to LIT.
- in_last on a MARKER is a protocol error. The frame end is carried on the length token instead.
- Reset values: state = LIT, cnt = 0, out_valid = 0, out_data = 0, out_last = 0, err = 0.
- A reset mid-run discards the remaining zeros and any held output.

## Timing
- Latency is 1 cycle from token accept to out_valid.
- Throughput is 1 coefficient/cycle with out_ready held high, including back-to-back literals.
- Run of N costs 2 input tokens and N output cycles. in_ready is low for N−1 of them.
- MARKER accept produces a 1-cycle output bubble.
- Backpressure: out_data, out_last, and out_valid stay stable while out_valid & !out_ready.
- in_ready is combinational from state, out_valid, and out_ready. It has no dependency on in_valid.

## Configuration
- RLE_DEC_ERR_EN defined:
  - The err port exists.
  - It sets on the cycle after accepting N = 0 or a MARKER with in_last.
  - It stays set until reset.
- RLE_DEC_ERR_EN undefined:
  - The err port and its logic are absent.
  - N = 0 is silently dropped.
  - in_last on a MARKER is ignored.

## Structure
- Package rle_pkg holds:
  - state enum {LIT, LEN, RUN}
  - RLE_MARKER constant (0)
  - default DATA_W/LEN_W localparams, shared with the encoder
- One sub-module, rle_out_reg: a single-entry valid/ready output register carrying data + last. The FSM and counter stay in the top.

## Test plan
- Literals 5, −3, 7 with out_ready = 1 → out 5, −3, 7 on consecutive cycles, 1 cycle after each accept.
- Tokens 9, 0, 4, −2 → out 9, 0, 0, 0, 0, −2. in_ready is low for 3 cycles during the run.
- Tokens 0, 1 with in_last on the length token → a single 0 with out_last = 1. FSM returns to LIT.
- Run 0, 3 with out_ready toggled 1,0,0,1,1 → three zeros delivered, values stable while stalled, none lost or duplicated.
- With the macro: tokens 0, 0 → no output, err = 1 the next cycle, still 1 after 10 further literals, cleared by rst_n low for 1 cycle.
- Reset asserted in RUN with 100 zeros pending → next cycle out_valid = 0 and in_ready = 1. A following literal 6 emerges normally.
